// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned NUM_REGS = 32;

  // Occupancy of a one-entry holding slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // One-hot decode of a register address into the pending bitmap.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    addr_onehot = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry holding buffer for a writeback requester; reloads in the cycle it is granted.
module wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  output logic    ready_c_o,
  input  wr_req_t req_i,
  input  logic    grant_i,
  output logic    full_o,
  output wr_req_t req_o
);

  slot_state_e state_q, state_d;
  wr_req_t     req_q, req_d;
  logic        xfer_c;

  // Ready depends only on occupancy and grant, never on valid_i.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ready_c_o = (state_q == EMPTY) || grant_i;
    xfer_c    = valid_i && ready_c_o;
    case (state_q)
      EMPTY: begin
        if (xfer_c) begin
          state_d = FULL;
          req_d   = req_i;
        end
      end
      FULL: begin
        if (xfer_c) begin
          req_d = req_i;
        end else if (grant_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Slot state and payload registers; reset discards any held write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign full_o = (state_q == FULL);
  assign req_o  = req_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W       = regfile_wb_arbiter_pkg::ADDR_W,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              ReqValid0,
  output logic              ReqReady0,
  input  logic [ADDR_W-1:0] ReqAddr0,
  input  logic [DATA_W-1:0] ReqData0,
  input  logic              ReqValid1,
  output logic              ReqReady1,
  input  logic [ADDR_W-1:0] ReqAddr1,
  input  logic [DATA_W-1:0] ReqData1,
  output logic [ADDR_W-1:0] WrtAddress,
  output logic [DATA_W-1:0] DataIn,
  output logic              Wenable,
  output logic [31:0]       Pending
);

  wr_req_t              slot_in  [NUM_REQ];
  wr_req_t              slot_out [NUM_REQ];
  logic [NUM_REQ-1:0]   valid;
  logic [NUM_REQ-1:0]   ready;
  logic [NUM_REQ-1:0]   full;
  logic [NUM_REQ-1:0]   grant;
  wr_req_t              sel;

  logic                 rr_q, rr_d;
  logic [ADDR_W-1:0]    wrt_addr_q, wrt_addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 wen_q, wen_d;

  // Requester payload packing.
  always_comb begin
    valid[0]        = ReqValid0;
    valid[1]        = ReqValid1;
    slot_in[0].addr = ReqAddr0;
    slot_in[0].data = ReqData0;
    slot_in[1].addr = ReqAddr1;
    slot_in[1].data = ReqData1;
  end

  wb_slot u_slot0 (
    .clk       (clk),
    .rst       (Reset),
    .valid_i   (valid[0]),
    .ready_c_o (ready[0]),
    .req_i     (slot_in[0]),
    .grant_i   (grant[0]),
    .full_o    (full[0]),
    .req_o     (slot_out[0])
  );

  wb_slot u_slot1 (
    .clk       (clk),
    .rst       (Reset),
    .valid_i   (valid[1]),
    .ready_c_o (ready[1]),
    .req_i     (slot_in[1]),
    .grant_i   (grant[1]),
    .full_o    (full[1]),
    .req_o     (slot_out[1])
  );

  // Grant selection: a lone full slot always wins; a contest goes to rr_q and hands priority to the loser.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    if (full[0] && full[1]) begin
      grant[rr_q] = 1'b1;
      rr_d        = ~rr_q;
    end else if (full[0]) begin
      grant[0] = 1'b1;
    end else if (full[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Output stage next value; address/data hold when nothing is granted.
  always_comb begin
    wen_d      = 1'b0;
    wrt_addr_d = wrt_addr_q;
    data_d     = data_q;
    sel        = grant[1] ? slot_out[1] : slot_out[0];
    if (|grant) begin
      wrt_addr_d = sel.addr;
      data_d     = sel.data;
      wen_d      = !(R0_HARDWIRED && (sel.addr == '0));
    end
  end

  // Priority pointer and write-port registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rr_q       <= 1'b0;
      wrt_addr_q <= '0;
      data_q     <= '0;
      wen_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      wrt_addr_q <= wrt_addr_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
    end
  end

  // Pending bitmap from state only: held slots plus the write being presented this cycle.
  always_comb begin
    Pending = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (full[i]) begin
        Pending = Pending | addr_onehot(slot_out[i].addr);
      end
    end
    if (wen_q) begin
      Pending = Pending | addr_onehot(wrt_addr_q);
    end
  end

  assign ReqReady0  = ready[0];
  assign ReqReady1  = ready[1];
  assign WrtAddress = wrt_addr_q;
  assign DataIn     = data_q;
  assign Wenable    = wen_q;

  // A hardwired r0 must never see a write strobe.
  a_no_r0_write: assert property (@(posedge clk) disable iff (Reset)
    !(R0_HARDWIRED && wen_q && (wrt_addr_q == '0)));

  // An empty slot always offers ready.
  a_empty_ready: assert property (@(posedge clk) disable iff (Reset)
    (!full[0] -> ready[0]) && (!full[1] -> ready[1]));

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32x32 register file. Shares the register file's single write port (DataIn, WrtAddress, Wenable) between two writeback requesters: requester 0 is ALU writeback, requester 1 is load writeback. Each requester has a one-entry holding slot, and a round-robin grant selects which slot drives the port. It also publishes a pending-write bitmap for hazard checks on the read ports.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- R0_HARDWIRED, 1, when 1, writes to address 0 are accepted but never drive Wenable

Ports:
- clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high reset
- ReqValid0 / ReqValid1  in  1  requester has a write
- ReqReady0 / ReqReady1  out  1  slot can accept this cycle
- ReqAddr0 / ReqAddr1  in  ADDR_W  destination register
- ReqData0 / ReqData1  in  DATA_W  write data
- WrtAddress  out  ADDR_W  to register file, registered
- DataIn  out  DATA_W  to register file, registered
- Wenable  out  1  to register file, registered
- Pending  out  32  bit k=1 while a write to register k is in a slot or in the output stage

## Operation
- Handshake: transfer when ReqValidi & ReqReadyi at a rising edge. ReqReadyi = slot i empty OR slot i granted this cycle. ReqReadyi never depends on ReqValidi.
- Slot i holds {addr, data} from transfer until granted. A slot can reload in the same cycle it is granted.
- Arbiter:
  - If only one slot is full, that slot is granted.
  - If both are full, the slot indicated by the priority pointer RR is granted.
  - After any two-way contest, RR flips to the loser.
  - RR does not change when only one slot is full.
- Grant loads the output stage: WrtAddress/DataIn take the slot contents. Wenable=1 unless R0_HARDWIRED=1 and addr=0.
- With no grant, Wenable=0. WrtAddress/DataIn hold their last values.
- Same-address collision (both slots full, same addr): both writes occur, in grant order. The later grant wins in the register file. No merging.
- Pending = OR of one-hot(addr) over full slots, plus one-hot(WrtAddress) when Wenable=1. Combinational from state only. Address 0 bits are included even when R0_HARDWIRED=1.
- States per slot: EMPTY, FULL. Transitions:
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on grant without transfer.
  - FULL -> FULL on grant with transfer.

## Timing
- Reset (synchronous, dominant over all other inputs) produces:
  - Slots EMPTY, RR=0
  - Wenable=0, WrtAddress=0, DataIn=0
  - Pending=0, ReqReady0=ReqReady1=1 in the following cycle
- Reset mid-operation discards buffered writes. No Wenable pulse is issued for them.
- Latency: transfer at edge E0 -> grant in cycle after E0 -> Wenable high in cycle after E1 -> register file written at E2. Uncontended latency is 2 cycles from accept to Wenable.
- Throughput: one write per cycle sustained. A single requester streaming back-to-back sees ReqReady held at 1.
- Under contention each requester gets at least every other grant. Worst-case wait is 1 extra cycle.

## Structure
- Shared package: DATA_W, ADDR_W, NUM_REQ=2, slot state enum {EMPTY, FULL}, and a write-request struct {addr, data}.
- One sub-module, wb_slot: the one-entry holding buffer with valid/ready, grant input, and addr/data outputs. It is instantiated twice.
- Arbiter, RR pointer, output registers and Pending decode sit in the top level.

## Test plan
- Reset, then a single write to r5=0xDEADBEEF from requester 0: Wenable=1 two cycles after accept, WrtAddress=5, DataIn=0xDEADBEEF, Pending[5]=1 until the cycle after the Wenable pulse.
- Both requesters valid every cycle (r1 ← 0x11 from req0, r2 ← 0x22 from req1): grants alternate 0,1,0,1; each ReqReady is high every other cycle; no write is lost.
- Same-cycle accept, both to r7 (0xAAAA from req0, 0xBBBB from req1) with RR=0: req0 is written first and req1 second; r7 reads 0xBBBB.
- R0_HARDWIRED=1, write r0=0x1234: the handshake completes, Wenable stays 0, and Pending[0] pulses for one cycle.
- Reset asserted while both slots are FULL: no Wenable follows; the next cycle shows Pending=0 and both ReqReady=1.
- Requester 1 streams 8 back-to-back writes to r8..r15 while requester 0 is idle: Wenable is high for 8 consecutive cycles and the addresses come out in order.
